// File: rtl/spi_duplex.sv
// Full-duplex SPI loopback: a master and a slave joined by internal sclk,
// cs_n, mosi and miso nets so mode handling and the clock divider can be
// exercised together before either side is used standalone.
module spi_duplex #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SPI_FREQ   = 500_000,
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b1,
    parameter bit CPHA       = 1'b1
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  spi_m_start,
    input  logic [DATA_WIDTH-1:0] data_m_send,
    output logic                  spi_m_done,
    output logic [DATA_WIDTH-1:0] data_m_recv,
    input  logic [DATA_WIDTH-1:0] data_s_send,
    output logic                  spi_s_done,
    output logic [DATA_WIDTH-1:0] data_s_recv
);

    localparam int HP     = CLK_FREQ / (2 * SPI_FREQ);
    localparam int DIV_W  = $clog2(HP);
    localparam int EDGES  = 2 * DATA_WIDTH;
    localparam int EDGE_W = $clog2(EDGES + 1);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [DIV_W-1:0]  HP_LAST   = DIV_W'(HP - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES - 1);
    localparam logic [BIT_W-1:0]  BIT_FULL  = BIT_W'(DATA_WIDTH);
    localparam bit                SAMPLE_ON_RISE = (CPOL == CPHA);

    typedef enum logic [2:0] {
        M_IDLE,
        M_LEAD,
        M_XFER,
        M_TRAIL,
        M_DONE
    } mstate_t;

    // Internal SPI bus between master and slave
    logic w_sclk;
    logic w_csN;
    logic w_mosi;
    logic w_miso;

    // Master state
    mstate_t                r_mState;
    mstate_t                w_mNext;
    logic [DIV_W-1:0]       r_divCnt;
    logic [EDGE_W-1:0]      r_edgeCnt;
    logic                   r_sclk;
    logic                   r_csN;
    logic                   r_mosi;
    logic [DATA_WIDTH-1:0]  r_mTx;
    logic [DATA_WIDTH-1:0]  r_mRx;
    logic                   r_mDone;
    logic [DATA_WIDTH-1:0]  r_mRecv;

    // Slave state
    logic                   r_sclkD;
    logic                   r_csD;
    logic                   r_miso;
    logic [DATA_WIDTH-1:0]  r_sTx;
    logic [DATA_WIDTH-1:0]  r_sRx;
    logic [BIT_W-1:0]       r_sBitCnt;
    logic                   r_sDone;
    logic [DATA_WIDTH-1:0]  r_sRecv;

    logic w_hpEnd;
    logic w_lastEdge;
    logic w_mSampleEdge;
    logic w_csFall;
    logic w_csRise;
    logic w_sRise;
    logic w_sFall;
    logic w_sSample;
    logic w_sShift;
    logic [BIT_W-1:0]      w_sAlignShift;
    logic [DATA_WIDTH-1:0] w_sAligned;

    assign w_sclk = r_sclk;
    assign w_csN  = r_csN;
    assign w_mosi = r_mosi;
    assign w_miso = r_miso;

    assign w_hpEnd    = (r_divCnt == HP_LAST);
    assign w_lastEdge = (r_edgeCnt == EDGE_LAST);
    // Leading edges (even index) sample when CPHA=0, trailing edges when CPHA=1
    assign w_mSampleEdge = (r_edgeCnt[0] == CPHA);

    assign w_csFall  = r_csD & ~w_csN;
    assign w_csRise  = ~r_csD & w_csN;
    assign w_sRise   = w_sclk & ~r_sclkD;
    assign w_sFall   = ~w_sclk & r_sclkD;
    assign w_sSample = SAMPLE_ON_RISE ? w_sRise : w_sFall;
    assign w_sShift  = SAMPLE_ON_RISE ? w_sFall : w_sRise;

    // A short transfer leaves its bits in the LSBs; move them to the top
    assign w_sAlignShift = BIT_FULL - r_sBitCnt;
    assign w_sAligned    = r_sRx << w_sAlignShift;

    assign spi_m_done  = r_mDone;
    assign data_m_recv = r_mRecv;
    assign spi_s_done  = r_sDone;
    assign data_s_recv = r_sRecv;

    // Master state register
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            r_mState <= M_IDLE;
        end else begin
            r_mState <= w_mNext;
        end
    end

    // Master next-state: each timed phase ends on the half-period boundary
    always_comb begin
        w_mNext = r_mState;
        case (r_mState)
            M_IDLE:  if (spi_m_start) w_mNext = M_LEAD;
            M_LEAD:  if (w_hpEnd) w_mNext = M_XFER;
            M_XFER:  if (w_hpEnd && w_lastEdge) w_mNext = M_TRAIL;
            M_TRAIL: if (w_hpEnd) w_mNext = M_DONE;
            M_DONE:  w_mNext = M_IDLE;
            default: w_mNext = M_IDLE;
        endcase
    end

    // Master datapath: divider, sclk generation, shifting and done pulse
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            r_divCnt  <= '0;
            r_edgeCnt <= '0;
            r_sclk    <= CPOL;
            r_csN     <= 1'b1;
            r_mosi    <= 1'b0;
            r_mTx     <= '0;
            r_mRx     <= '0;
            r_mDone   <= 1'b0;
            r_mRecv   <= '0;
        end else begin
            r_mDone <= 1'b0;
            case (r_mState)
                M_IDLE: begin
                    r_divCnt  <= '0;
                    r_edgeCnt <= '0;
                    if (spi_m_start) begin
                        r_csN <= 1'b0;
                        r_mRx <= '0;
                        if (CPHA == 1'b0) begin
                            r_mosi <= data_m_send[DATA_WIDTH-1];
                            r_mTx  <= data_m_send << 1;
                        end else begin
                            r_mTx  <= data_m_send;
                        end
                    end
                end
                M_LEAD: begin
                    r_divCnt <= w_hpEnd ? '0 : r_divCnt + 1'b1;
                end
                M_XFER: begin
                    if (w_hpEnd) begin
                        r_divCnt  <= '0;
                        r_sclk    <= ~r_sclk;
                        r_edgeCnt <= r_edgeCnt + 1'b1;
                        if (w_mSampleEdge) begin
                            r_mRx <= {r_mRx[DATA_WIDTH-2:0], w_miso};
                        end else if (!w_lastEdge) begin
                            r_mosi <= r_mTx[DATA_WIDTH-1];
                            r_mTx  <= r_mTx << 1;
                        end
                    end else begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end
                end
                M_TRAIL: begin
                    if (w_hpEnd) begin
                        r_divCnt <= '0;
                        r_csN    <= 1'b1;
                        r_mDone  <= 1'b1;
                        r_mRecv  <= r_mRx;
                    end else begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end
                end
                default: begin
                    r_divCnt <= '0;
                end
            endcase
        end
    end

    // Slave: delayed copies of sclk/cs_n for edge detection, then shift/sample
    always_ff @(posedge clk or posedge arstn) begin
        if (arstn) begin
            r_sclkD   <= CPOL;
            r_csD     <= 1'b1;
            r_miso    <= 1'b0;
            r_sTx     <= '0;
            r_sRx     <= '0;
            r_sBitCnt <= '0;
            r_sDone   <= 1'b0;
            r_sRecv   <= '0;
        end else begin
            r_sclkD <= w_sclk;
            r_csD   <= w_csN;
            r_sDone <= 1'b0;
            if (w_csFall) begin
                r_miso    <= data_s_send[DATA_WIDTH-1];
                r_sRx     <= '0;
                r_sBitCnt <= '0;
                if (CPHA == 1'b0) begin
                    r_sTx <= data_s_send << 1;
                end else begin
                    r_sTx <= data_s_send;
                end
            end else if (w_csRise) begin
                r_sDone <= 1'b1;
                r_sRecv <= w_sAligned;
            end else if (!w_csN) begin
                if (w_sSample) begin
                    r_sRx <= {r_sRx[DATA_WIDTH-2:0], w_mosi};
                    if (r_sBitCnt != BIT_FULL) begin
                        r_sBitCnt <= r_sBitCnt + 1'b1;
                    end
                end
                if (w_sShift) begin
                    r_miso <= r_sTx[DATA_WIDTH-1];
                    r_sTx  <= r_sTx << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_duplex.sv
// Directed bench for spi_duplex: four instances, one per SPI mode, share the
// stimulus so every test covers all (CPOL,CPHA) combinations at once.
module tb_spi_duplex;

    // Instance i mode: 0=(1,1) 1=(0,0) 2=(0,1) 3=(1,0)
    localparam logic [3:0] CPOL_V = 4'b1001;
    localparam logic [3:0] CPHA_V = 4'b0101;
    localparam int BOUND = 3000;

    logic       clk = 1'b0;
    logic       arstn;
    logic       start;
    logic [7:0] mSend;
    logic [7:0] sSend;
    logic [3:0] mDone;
    logic [3:0] sDone;
    logic [7:0] mRecv [4];
    logic [7:0] sRecv [4];
    logic [3:0] sclkW;
    logic [3:0] csW;
    logic [3:0] mosiW;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mCnt [4];
    int sCnt [4];
    int baseM [4];
    int baseS [4];
    logic [7:0] mCap [4];
    logic [7:0] sCap [4];
    int mCyc = 0;
    int sCyc = 0;
    int sclkRise = 0;
    logic sclkPrev = 1'b1;

    always #5 clk = ~clk;

    spi_duplex #(.CPOL(1'b1), .CPHA(1'b1)) u11 (
        .clk(clk), .arstn(arstn), .spi_m_start(start), .data_m_send(mSend),
        .spi_m_done(mDone[0]), .data_m_recv(mRecv[0]), .data_s_send(sSend),
        .spi_s_done(sDone[0]), .data_s_recv(sRecv[0]));
    spi_duplex #(.CPOL(1'b0), .CPHA(1'b0)) u00 (
        .clk(clk), .arstn(arstn), .spi_m_start(start), .data_m_send(mSend),
        .spi_m_done(mDone[1]), .data_m_recv(mRecv[1]), .data_s_send(sSend),
        .spi_s_done(sDone[1]), .data_s_recv(sRecv[1]));
    spi_duplex #(.CPOL(1'b0), .CPHA(1'b1)) u01 (
        .clk(clk), .arstn(arstn), .spi_m_start(start), .data_m_send(mSend),
        .spi_m_done(mDone[2]), .data_m_recv(mRecv[2]), .data_s_send(sSend),
        .spi_s_done(sDone[2]), .data_s_recv(sRecv[2]));
    spi_duplex #(.CPOL(1'b1), .CPHA(1'b0)) u10 (
        .clk(clk), .arstn(arstn), .spi_m_start(start), .data_m_send(mSend),
        .spi_m_done(mDone[3]), .data_m_recv(mRecv[3]), .data_s_send(sSend),
        .spi_s_done(sDone[3]), .data_s_recv(sRecv[3]));

    assign sclkW = {u10.w_sclk, u01.w_sclk, u00.w_sclk, u11.w_sclk};
    assign csW   = {u10.w_csN,  u01.w_csN,  u00.w_csN,  u11.w_csN};
    assign mosiW = {u10.w_mosi, u01.w_mosi, u00.w_mosi, u11.w_mosi};

    // Monitor: count done pulses, capture data on them, count sclk rises
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (mDone[i] === 1'b1) begin
                mCnt[i] = mCnt[i] + 1;
                mCap[i] = mRecv[i];
                if (i == 0) mCyc = cyc;
            end
            if (sDone[i] === 1'b1) begin
                sCnt[i] = sCnt[i] + 1;
                sCap[i] = sRecv[i];
                if (i == 0) sCyc = cyc;
            end
        end
        if (sclkW[0] === 1'b1 && sclkPrev === 1'b0) sclkRise = sclkRise + 1;
        sclkPrev = sclkW[0];
    end

    task automatic snapshot();
        for (int i = 0; i < 4; i++) begin
            baseM[i] = mCnt[i];
            baseS[i] = sCnt[i];
        end
    endtask

    function automatic bit allDone();
        bit d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (mCnt[i] <= baseM[i] || sCnt[i] <= baseS[i]) d = 1'b0;
        end
        return d;
    endfunction

    task automatic pulseStart(input logic [7:0] m, input logic [7:0] s);
        @(posedge clk); #1;
        mSend = m;
        sSend = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitAllDone(output bit ok);
        int n = 0;
        while (!allDone() && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (n < BOUND);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arstn = 1'b1;
        waitCycles(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (csW[i] !== 1'b1 || sclkW[i] !== CPOL_V[i] || mosiW[i] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_bus inst%0d: got cs=%b sclk=%b mosi=%b expected cs=1 sclk=%b mosi=0",
                         i, csW[i], sclkW[i], mosiW[i], CPOL_V[i]);
            end
            checks++;
            if (mDone[i] !== 1'b0 || sDone[i] !== 1'b0 || mRecv[i] !== 8'h00 || sRecv[i] !== 8'h00) begin
                failures++;
                $display("[TB] FAIL reset_out inst%0d: got md=%b sd=%b mr=%h sr=%h expected 0 0 00 00",
                         i, mDone[i], sDone[i], mRecv[i], sRecv[i]);
            end
        end
        arstn = 1'b0;
        waitCycles(2);
    endtask

    task automatic test_basic();
        bit ok;
        int rise0;
        snapshot();
        rise0 = sclkRise;
        pulseStart(8'hAB, 8'hCD);
        waitAllDone(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL basic_timeout: got no done within %0d cycles expected done", BOUND);
        end
        waitCycles(3);
        checks++;
        if (sCap[0] !== 8'hAB || mCap[0] !== 8'hCD) begin
            failures++;
            $display("[TB] FAIL basic_data: got s=%h m=%h expected s=ab m=cd", sCap[0], mCap[0]);
        end
        checks++;
        if (sclkRise - rise0 != 8) begin
            failures++;
            $display("[TB] FAIL basic_sclk_count: got %0d expected 8", sclkRise - rise0);
        end
        checks++;
        if (sclkW[0] !== 1'b1 || csW[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_idle: got sclk=%b cs=%b expected 1 1", sclkW[0], csW[0]);
        end
        checks++;
        if (sCyc - mCyc < 1 || sCyc - mCyc > 2) begin
            failures++;
            $display("[TB] FAIL basic_sdone_lag: got %0d expected 1..2", sCyc - mCyc);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        waitCycles(10);
        snapshot();
        pulseStart(8'hEE, 8'hFF);
        waitCycles(400);
        checks++;
        if (mRecv[0] !== 8'hCD || sRecv[0] !== 8'hAB) begin
            failures++;
            $display("[TB] FAIL b2b_hold: got m=%h s=%h expected m=cd s=ab", mRecv[0], sRecv[0]);
        end
        waitAllDone(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL b2b_timeout: got no done within %0d cycles expected done", BOUND);
        end
        waitCycles(3);
        checks++;
        if (sCap[0] !== 8'hEE || mCap[0] !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL b2b_data: got s=%h m=%h expected s=ee m=ff", sCap[0], mCap[0]);
        end
    endtask

    task automatic test_modes();
        bit ok;
        waitCycles(10);
        snapshot();
        pulseStart(8'hAB, 8'hCD);
        waitCycles(20);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (csW[i] !== 1'b0 || sclkW[i] !== CPOL_V[i]) begin
                failures++;
                $display("[TB] FAIL mode_lead inst%0d: got cs=%b sclk=%b expected cs=0 sclk=%b",
                         i, csW[i], sclkW[i], CPOL_V[i]);
            end
            if (CPHA_V[i] == 1'b0) begin
                checks++;
                if (mosiW[i] !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL mode_lead_msb inst%0d: got mosi=%b expected 1", i, mosiW[i]);
                end
            end
        end
        waitAllDone(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL mode_timeout: got no done within %0d cycles expected done", BOUND);
        end
        waitCycles(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sCap[i] !== 8'hAB || mCap[i] !== 8'hCD || sclkW[i] !== CPOL_V[i]) begin
                failures++;
                $display("[TB] FAIL mode_data inst%0d: got s=%h m=%h sclk=%b expected s=ab m=cd sclk=%b",
                         i, sCap[i], mCap[i], sclkW[i], CPOL_V[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        bit ok;
        waitCycles(10);
        snapshot();
        pulseStart(8'hAB, 8'hCD);
        waitCycles(300);
        pulseStart(8'h55, 8'h55);
        waitAllDone(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL ignore_timeout: got no done within %0d cycles expected done", BOUND);
        end
        waitCycles(1200);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sCap[i] !== 8'hAB || mCap[i] !== 8'hCD ||
                mCnt[i] - baseM[i] != 1 || sCnt[i] - baseS[i] != 1) begin
                failures++;
                $display("[TB] FAIL ignore_start inst%0d: got s=%h m=%h mdones=%0d sdones=%0d expected ab cd 1 1",
                         i, sCap[i], mCap[i], mCnt[i] - baseM[i], sCnt[i] - baseS[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        waitCycles(10);
        snapshot();
        pulseStart(8'hAB, 8'hCD);
        waitCycles(455);
        arstn = 1'b1;
        waitCycles(1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (csW[i] !== 1'b1 || sclkW[i] !== CPOL_V[i] || mRecv[i] !== 8'h00 || sRecv[i] !== 8'h00) begin
                failures++;
                $display("[TB] FAIL abort_state inst%0d: got cs=%b sclk=%b mr=%h sr=%h expected 1 %b 00 00",
                         i, csW[i], sclkW[i], mRecv[i], sRecv[i], CPOL_V[i]);
            end
        end
        arstn = 1'b0;
        waitCycles(1000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mCnt[i] != baseM[i] || sCnt[i] != baseS[i]) begin
                failures++;
                $display("[TB] FAIL abort_nodone inst%0d: got mdones=%0d sdones=%0d expected 0 0",
                         i, mCnt[i] - baseM[i], sCnt[i] - baseS[i]);
            end
        end
        pulseStart(8'h3C, 8'hC3);
        waitAllDone(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL abort_timeout: got no done within %0d cycles expected done", BOUND);
        end
        waitCycles(3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sCap[i] !== 8'h3C || mCap[i] !== 8'hC3) begin
                failures++;
                $display("[TB] FAIL abort_recover inst%0d: got s=%h m=%h expected s=3c m=c3",
                         i, sCap[i], mCap[i]);
            end
        end
    endtask

    task automatic test_patterns();
        logic [7:0] mVec [2];
        logic [7:0] sVec [2];
        bit ok;
        mVec[0] = 8'h00; sVec[0] = 8'hFF;
        mVec[1] = 8'h80; sVec[1] = 8'h01;
        for (int v = 0; v < 2; v++) begin
            waitCycles(10);
            snapshot();
            pulseStart(mVec[v], sVec[v]);
            waitAllDone(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL pattern_timeout vec%0d: got no done expected done", v);
            end
            waitCycles(3);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (sCap[i] !== mVec[v] || mCap[i] !== sVec[v]) begin
                    failures++;
                    $display("[TB] FAIL pattern vec%0d inst%0d: got s=%h m=%h expected s=%h m=%h",
                             v, i, sCap[i], mCap[i], mVec[v], sVec[v]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mCnt[i] = 0;
            sCnt[i] = 0;
            mCap[i] = 8'h00;
            sCap[i] = 8'h00;
        end
        arstn = 1'b1;
        start = 1'b0;
        mSend = 8'h00;
        sSend = 8'h00;
        test_reset();
        test_basic();
        test_back_to_back();
        test_modes();
        test_ignored_start();
        test_reset_abort();
        test_patterns();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_duplex.md
Name: spi_duplex

Overview:
- Self-contained full-duplex SPI loopback block: one SPI master and one SPI slave inside one module, wired together by internal sclk, cs_n, mosi and miso nets.
- A single start pulse makes the master send data_m_send to the slave while the slave simultaneously returns data_s_send to the master.
- Used to verify SPI mode handling (CPOL/CPHA) and the clock divider before the master or slave is deployed standalone.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- SPI_FREQ, 500_000, sclk frequency in Hz. Half-period HP = CLK_FREQ/(2*SPI_FREQ) clk cycles; default HP = 50. HP must be at least 4.
- DATA_WIDTH, 8, bits per transfer.
- CPOL, 1, sclk idle level (0 = low, 1 = high).
- CPHA, 1, phase select:
  - CPOL^CPHA==0: sample on sclk rising edge, shift on falling edge.
  - CPOL^CPHA==1: sample on falling edge, shift on rising edge.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- arstn, input, 1, asynchronous reset, active-high.
- spi_m_start, input, 1, one-clk pulse that starts a master transfer.
- data_m_send, input, DATA_WIDTH, master transmit word; latched on the start cycle.
- spi_m_done, output, 1, one-clk pulse; data_m_recv is valid in the same cycle.
- data_m_recv, output, DATA_WIDTH, word the master received on miso.
- data_s_send, input, DATA_WIDTH, slave transmit word; latched when cs_n falls.
- spi_s_done, output, 1, one-clk pulse; data_s_recv is valid in the same cycle.
- data_s_recv, output, DATA_WIDTH, word the slave received on mosi.

Behaviour:
- Reset (arstn=1, asynchronous):
  - master and slave go to IDLE; cs_n=1, sclk=CPOL, mosi=0, miso=0.
  - spi_m_done=0, spi_s_done=0, data_m_recv=0, data_s_recv=0, divider counter and bit counters cleared.
  - Reset asserted mid-transfer aborts the transfer immediately. No done pulse is generated for the aborted transfer.
- Bit order: MSB first in both directions.
- Master FSM states: IDLE -> LEAD -> XFER -> TRAIL -> DONE -> IDLE.
  - IDLE: spi_m_start=1 latches data_m_send into the TX shift register and drives cs_n=0 on the next cycle. Enter LEAD.
  - LEAD: hold sclk=CPOL for HP cycles. With CPHA=0, mosi carries the MSB during this time.
  - XFER: toggle sclk every HP cycles for exactly 2*DATA_WIDTH edges.
    - Sample edge: shift miso into the RX register.
    - Shift edge: present the next bit on mosi.
    - CPHA=1: first edge is a shift edge; the MSB appears on it.
    - CPHA=0: the final trailing edge shifts nothing.
  - TRAIL: sclk back at CPOL; hold cs_n=0 for HP cycles, then drive cs_n=1.
  - DONE: spi_m_done=1 for one cycle; data_m_recv is updated in the same cycle and held until the next done.
- spi_m_start while not in IDLE is ignored. Start and reset in the same cycle: reset wins.
- Slave:
  - Keeps one-cycle registered copies of sclk and cs_n and detects edges on them (same clock domain, no extra synchronizer).
  - cs_n falling: load data_s_send into its TX register, clear its bit counter, drive the MSB on miso. This is in time for the CPHA=0 LEAD phase.
  - Each sclk edge: detect it, then sample or shift with the same CPOL/CPHA rules as the master.
  - Edges while cs_n=1 are ignored.
  - cs_n rising: spi_s_done=1 for one cycle, with data_s_recv updated from the RX register in the same cycle.
  - A cs_n rise after fewer than DATA_WIDTH bits still pulses done with the partial word, left-aligned with zeros in the unfilled LSBs.
- Latency (default parameters): start to spi_m_done is about (2*DATA_WIDTH+2)*HP + 3 = 903 clk cycles.
  - spi_s_done fires within 2 cycles of spi_m_done.
  - Both done pulses must precede any subsequent start.
- data_m_send and data_s_send may change freely outside their latch points.

Test Plan:
- Defaults (CPOL=1, CPHA=1): reset, start with m=0xAB, s=0xCD -> data_s_recv=0xAB at spi_s_done and data_m_recv=0xCD at spi_m_done; exactly 8 sclk cycles, sclk idles high.
- Back-to-back: 10 cycles after spi_m_done, start with m=0xEE, s=0xFF -> data_s_recv=0xEE, data_m_recv=0xFF; the previous outputs hold until those done pulses.
- Repeat 0xAB/0xCD for (CPOL,CPHA) = (0,0), (0,1), (1,0) -> correct data in both directions; sclk idle level equals CPOL; for CPHA=0 the MSB is valid during LEAD.
- Start pulsed again mid-transfer with m=0x55 -> ignored; the current 0xAB/0xCD transfer completes unchanged, with one done pulse each.
- Assert arstn at bit 4 -> cs_n=1, sclk=CPOL, no done pulses, outputs=0; a following 0x3C/0xC3 transfer passes both ways.
- Patterns 0x00/0xFF and 0x80/0x01 -> MSB-first ordering verified both directions.
